// File: rtl/cache_mem_sched_if.sv
// Bundle between the cache control/main memory side and the memory-port scheduler.
// slave = the scheduler, master = the cache control and memory environment around it.
interface cache_mem_sched_if #(
   parameter int ADDR_W = 10
);
   logic              rf_req;
   logic [ADDR_W-1:0] rf_addr;
   logic              rf_done;
   logic [127:0]      rf_data;
   logic              wt_valid;
   logic              wt_ready;
   logic [ADDR_W-1:0] wt_addr;
   logic [31:0]       wt_data;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [127:0]      mem_write_data;
   logic [3:0]        mem_word_en;
   logic              mem_ack;
   logic [127:0]      mem_read_data;
   logic              wb_empty;

   modport slave (
      input  rf_req, rf_addr, wt_valid, wt_addr, wt_data, mem_ack, mem_read_data,
      output rf_done, rf_data, wt_ready, mem_req, mem_we, mem_addr, mem_write_data,
      output mem_word_en, wb_empty
   );

   modport master (
      output rf_req, rf_addr, wt_valid, wt_addr, wt_data, mem_ack, mem_read_data,
      input  rf_done, rf_data, wt_ready, mem_req, mem_we, mem_addr, mem_write_data,
      input  mem_word_en, wb_empty
   );
endinterface

// File: rtl/cache_mem_sched.sv
// Arbitrates the single main-memory port between block refills and posted word write-throughs.
// Refills win unless a buffered write targets the same block; then writes drain first.
//
// state | meaning
// IDLE  | no memory request outstanding; picks refill or head write each cycle
// RD    | block read outstanding, waiting for mem_ack
// WR    | head write-through outstanding, popped on mem_ack
module cache_mem_sched #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   cache_mem_sched_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, RD, WR} state_t;

   state_t            state;
   logic [ADDR_W-3:0] fifo_addr [DEPTH];
   logic [31:0]       fifo_data [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic [CW-1:0]     count_next;
   logic              push;
   logic              pop;
   logic              hazard;
   logic [DEPTH-1:0]  match;
   logic              unused_bits;

   assign push        = bus.wt_valid && bus.wt_ready;
   assign pop         = (state == WR) && bus.mem_req && bus.mem_ack;
   assign count_next  = count + CW'(push) - CW'(pop);
   assign bus.wb_empty = (count == '0) && (state != WR);
   assign unused_bits = ^{bus.rf_addr[3:0], bus.wt_addr[1:0]};

   // An entry is live when its offset from the head is below the occupancy count.
   always_comb begin
      match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match[i] = ({1'b0, PW'(i) - rd_ptr} < count) &&
                    (fifo_addr[i][ADDR_W-3:2] == bus.rf_addr[ADDR_W-1:4]);
      end
   end

   assign hazard = |match;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= bus.wt_addr[ADDR_W-1:2];
         fifo_data[wr_ptr] <= bus.wt_data;
      end
   end

   // wt_ready tracks the count register, so a pop into a full buffer cannot admit a push that cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         bus.wt_ready <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count        <= count_next;
         bus.wt_ready <= (count_next < CW'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= IDLE;
         bus.mem_req        <= 1'b0;
         bus.mem_we         <= 1'b0;
         bus.mem_addr       <= '0;
         bus.mem_write_data <= '0;
         bus.mem_word_en    <= '0;
         bus.rf_done        <= 1'b0;
         bus.rf_data        <= '0;
      end else begin
         bus.rf_done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.rf_req && !hazard) begin
                  state              <= RD;
                  bus.mem_req        <= 1'b1;
                  bus.mem_we         <= 1'b0;
                  bus.mem_addr       <= {bus.rf_addr[ADDR_W-1:4], 4'b0000};
                  bus.mem_word_en    <= 4'b0000;
                  bus.mem_write_data <= '0;
               end else if (count != '0) begin
                  state              <= WR;
                  bus.mem_req        <= 1'b1;
                  bus.mem_we         <= 1'b1;
                  bus.mem_addr       <= {fifo_addr[rd_ptr][ADDR_W-3:2], 4'b0000};
                  bus.mem_word_en    <= 4'b0001 << fifo_addr[rd_ptr][1:0];
                  bus.mem_write_data <= {4{fifo_data[rd_ptr]}};
               end
            end
            RD: begin
               if (bus.mem_req && bus.mem_ack) begin
                  bus.rf_data <= bus.mem_read_data;
                  bus.rf_done <= 1'b1;
                  bus.mem_req <= 1'b0;
                  state       <= IDLE;
               end
            end
            WR: begin
               if (bus.mem_req && bus.mem_ack) begin
                  bus.mem_req <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               bus.mem_req <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end
endmodule
